// File: rtl/crc_gen_param.sv
// Serial CRC generator: shifts message bits in while active is high, then
// streams the CRC_WIDTH-bit remainder out LSB first with a valid strobe.
module crc_gen_param #(
    parameter int                   CRC_WIDTH = 8,
    parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(8'h44),
    parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(8'hD8)
) (
    input  logic clk,
    input  logic rst,
    input  logic data,
    input  logic active,
    output logic crc,
    output logic valid,
    output logic busy
);

    localparam int CNT_W = $clog2(CRC_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [CRC_WIDTH-1:0] r, r_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 crc_next, valid_next, busy_next;

    // Feedback enters at the top bit unconditionally, so POLY's top bit is irrelevant.
    function automatic logic [CRC_WIDTH-1:0] step(input logic [CRC_WIDTH-1:0] cur,
                                                  input logic bit_in);
        logic                 fb;
        logic [CRC_WIDTH-1:0] nxt;
        fb  = bit_in ^ cur[0];
        nxt = (cur >> 1) ^ (POLY & {CRC_WIDTH{fb}});
        nxt[CRC_WIDTH-1] = fb;
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            r     <= SEED;
            cnt   <= '0;
            crc   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            r     <= r_next;
            cnt   <= cnt_next;
            crc   <= crc_next;
            valid <= valid_next;
            busy  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        r_next     = r;
        cnt_next   = cnt;
        crc_next   = 1'b0;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (active) begin
                    r_next     = step(SEED, data);
                    state_next = CALC;
                end
            end
            CALC: begin
                if (active) begin
                    r_next = step(r, data);
                end else begin
                    state_next = OUT;
                    valid_next = 1'b1;
                    crc_next   = r[0];
                    cnt_next   = '0;
                end
            end
            OUT: begin
                // Inputs are ignored here; the last bit returns to IDLE, never straight to CALC.
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    r_next     = r >> 1;
                    cnt_next   = cnt + CNT_W'(1);
                    crc_next   = r[1];
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                r_next     = SEED;
                cnt_next   = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_crc_gen_param.sv
// Bench for crc_gen_param: an 8-bit default instance and a 16-bit CCITT-style
// instance share stimulus; results are checked against a bit-serial reference model.
module tb_crc_gen_param;

    logic clk = 1'b0;
    logic rst, data, active;
    logic crc8, valid8, busy8;
    logic crc16, valid16, busy16;

    int total = 0;
    int bad   = 0;

    logic [15:0] got8, got16;
    int          cnt8, cnt16;
    logic        first8, first16, leak, end_busy;

    always #5 clk = ~clk;

    crc_gen_param dut8 (
        .clk(clk), .rst(rst), .data(data), .active(active),
        .crc(crc8), .valid(valid8), .busy(busy8)
    );

    crc_gen_param #(.CRC_WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF)) dut16 (
        .clk(clk), .rst(rst), .data(data), .active(active),
        .crc(crc16), .valid(valid16), .busy(busy16)
    );

    // Remainder after feeding nbits of msg (LSB first) into a freshly seeded register.
    function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                              input logic [31:0] seed,
                                              input logic [7:0] msg, input int nbits);
        logic [31:0] r;
        logic [31:0] top;
        logic        fb;
        r   = seed;
        top = 32'd1 << (w - 1);
        for (int i = 0; i < nbits; i++) begin
            fb = msg[i] ^ r[0];
            r  = r >> 1;
            if (fb) r = (r ^ (poly & ~top)) | top;
        end
        return r;
    endfunction

    task automatic run_frame(input logic [7:0] msg, input int nbits, input bit toggle_out);
        got8 = '0; got16 = '0; cnt8 = 0; cnt16 = 0; leak = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            active = 1'b1;
            data   = msg[i];
        end
        @(negedge clk);
        active = 1'b0;
        data   = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) begin
                first8  = valid8;
                first16 = valid16;
            end
            if (valid8) begin
                if (cnt8 < 16) got8[4'(cnt8)] = crc8;
                cnt8++;
            end else if (crc8) leak = 1'b1;
            if (valid16) begin
                if (cnt16 < 16) got16[4'(cnt16)] = crc16;
                cnt16++;
            end else if (crc16) leak = 1'b1;
            if (toggle_out && i < 7) begin
                active = 1'($urandom_range(0, 1));
                data   = 1'($urandom_range(0, 1));
            end else begin
                active = 1'b0;
                data   = 1'b0;
            end
        end
        end_busy = busy8 | busy16;
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp8,
                               input logic [7:0] msg, input int nbits);
        logic [15:0] exp16;
        exp16 = 16'(model_crc(16, 32'h1021, 32'hFFFF, msg, nbits));
        total++;
        if (got8 !== {8'h00, exp8}) begin
            bad++;
            $display("FAIL %s crc8 got=%h want=%h", name, got8[7:0], exp8);
        end
        total++;
        if (cnt8 !== 8) begin
            bad++;
            $display("FAIL %s valid8_cycles got=%0d want=8", name, cnt8);
        end
        total++;
        if (got16 !== exp16) begin
            bad++;
            $display("FAIL %s crc16 got=%h want=%h", name, got16, exp16);
        end
        total++;
        if (cnt16 !== 16) begin
            bad++;
            $display("FAIL %s valid16_cycles got=%0d want=16", name, cnt16);
        end
        total++;
        if ({first8, first16, leak, end_busy} !== 4'b1100) begin
            bad++;
            $display("FAIL %s latency/leak/busy got=%b want=1100", name,
                     {first8, first16, leak, end_busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; active = 1'b0; data = 1'b0;
        #3 rst = 1'b0;
        #1;
        total++;
        if ({valid8, crc8, busy8, valid16, crc16, busy16} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {valid8, crc8, busy8, valid16, crc16, busy16});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({valid8, busy8, busy16} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset got=%b want=000", {valid8, busy8, busy16});
        end
    endtask

    task automatic test_basic();
        run_frame(8'h00, 8, 1'b0);
        check_frame("byte00", 8'h14, 8'h00, 8);
    endtask

    task automatic test_reseed();
        run_frame(8'hFF, 8, 1'b0);
        check_frame("byteFF_reseed", 8'h72, 8'hFF, 8);
    endtask

    task automatic test_one_bit();
        run_frame(8'h00, 1, 1'b0);
        check_frame("one_bit", 8'h6C, 8'h00, 1);
    endtask

    task automatic test_out_ignore();
        run_frame(8'h00, 8, 1'b1);
        check_frame("out_ignore", 8'h14, 8'h00, 8);
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            active = 1'b1;
            data   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        total++;
        if ({busy8, busy16} !== 2'b11) begin
            bad++;
            $display("FAIL busy_in_calc got=%b want=11", {busy8, busy16});
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({valid8, crc8, busy8, valid16, crc16, busy16} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_calc got=%b want=000000",
                     {valid8, crc8, busy8, valid16, crc16, busy16});
        end
        active = 1'b0;
        data   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            active = 1'b1;
            data   = 1'b1;
        end
        @(negedge clk);
        active = 1'b0;
        data   = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({valid8, busy8, valid16, busy16} !== 4'b1111) begin
            bad++;
            $display("FAIL in_out_before_reset got=%b want=1111",
                     {valid8, busy8, valid16, busy16});
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({valid8, crc8, busy8, valid16, crc16, busy16} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_out got=%b want=000000",
                     {valid8, crc8, busy8, valid16, crc16, busy16});
        end
        @(negedge clk);
        rst = 1'b1;
        run_frame(8'hFF, 8, 1'b0);
        check_frame("after_reset_FF", 8'h72, 8'hFF, 8);
    endtask

    task automatic test_random();
        logic [7:0] msg;
        logic [7:0] exp8;
        for (int n = 0; n < 100; n++) begin
            msg  = 8'($urandom);
            exp8 = 8'(model_crc(8, 32'h44, 32'hD8, msg, 8));
            run_frame(msg, 8, 1'b0);
            check_frame("random", exp8, msg, 8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_reseed();
        test_one_bit();
        test_out_ignore();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
